chip_seq_gen: RTL and testbench
===============================

Name: chip_seq_gen

Overview:
Parametrised spreading-code sequencer for the spread-spectrum generator. It holds a writable chip table of 2^ADDR_W words of DATA_W bits. On command it plays the table out at a programmable chip rate, with a chip strobe, a sequence-start marker, and one-shot or loop modes. It replaces a bare fixed-ROM read with self-contained address generation, rate division and pipeline control, and feeds the spreader/modulator stage.

Parameters:
DATA_W, 8, chip word width
ADDR_W, 3, table address width; depth = 2^ADDR_W
DIV_W, 8, width of chip-rate divider

Ports:
clk_s  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  table write enable
wr_addr  in  ADDR_W  table write address
wr_data  in  DATA_W  table write data
start  in  1  start playback (IDLE only)
stop  in  1  abort playback
mode_loop  in  1  1 = wrap endlessly, 0 = one-shot
last_addr  in  ADDR_W  final table index played (length = last_addr+1)
chip_div  in  DIV_W  chip period = chip_div+1 clocks
data  out  DATA_W  current chip word (registered)
chip_stb  out  1  1-cycle pulse when data updates
seq_start  out  1  pulses with chip_stb for the index-0 chip
data_valid  out  1  high from first chip_stb until return to IDLE
busy  out  1  FSM not IDLE
done  out  1  1-cycle pulse at one-shot completion

Behaviour:
- Reset (async, immediate): FSM=IDLE; data=0; chip_stb, seq_start, data_valid, busy, done=0; address and divider counters=0; read pipeline flushed. Table contents are not reset.
- Table: synchronous write on wr_en, accepted in any state. Synchronous read with 1-cycle latency. Read and write to the same address in the same cycle returns the old word.
- States:
  - IDLE: start=1 and stop=0 at edge k latches mode_loop, last_addr, chip_div, then enters RUN; busy=1 from k+1.
  - RUN: divider counts 0..chip_div and then wraps. A read of the current address is issued in every cycle the divider is 0; the first read is at k+1.
  - On each issue, the address increments. If the issued address equals last_addr: loop mode wraps the address to 0 and stays in RUN; one-shot mode moves to FLUSH.
  - FLUSH: no further reads. For a last read at cycle t, return to IDLE in cycle max(t+chip_div+1, t+2). In that same cycle busy=0, data_valid=0 and done=1 for one cycle.
- Output timing: a read issued at cycle t gives data=word and chip_stb=1 at t+2. data holds until the next chip_stb. seq_start=1 at t+2 when the issued address was 0. data_valid goes to 1 at the first chip_stb.
- stop=1 in RUN or FLUSH: IDLE next cycle. In-flight reads are discarded (no chip_stb after stop). data_valid=0, data=0, no done pulse.
- start while busy is ignored. start and stop in the same cycle in IDLE: stop wins, stay IDLE. Config input changes while busy have no effect.
- last_addr=0: a single chip replays (loop) or plays once (one-shot). chip_div=0: one chip per clock, seamless back-to-back chip_stb.
- Reset asserted mid-run has the full reset effect immediately. Operation resumes only on a new start.

Test Plan:
- Load table 0x11,0x22,…,0x88 at addrs 0–7. chip_div=0, last_addr=3, one-shot, start at edge k -> chip_stb at k+3..k+6 with data 11,22,33,44; seq_start only at k+3; done and busy fall at k+6; no further strobes.
- Same table, chip_div=2, last_addr=1, loop -> chip_stb every 3 cycles, data 11,22,11,22,…; seq_start on every 11; no done; busy stays 1.
- Loop run with chip_div=0, stop asserted 1 cycle after an issue -> IDLE next cycle; no chip_stb for the in-flight read; data=0; data_valid=0; done=0.
- Write 0xA5 to addr 2 in the same cycle addr 2 is read -> old 0x33 is output. The next pass (loop) outputs 0xA5.
- Assert rst during RUN mid-chip -> all outputs 0 immediately. start with stop in the same cycle -> stays IDLE. A later start replays correctly from addr 0.
- last_addr=0, chip_div=4, one-shot -> a single chip_stb with 0x11 at k+3; done at k+6 (t+chip_div+1 with t=k+1).

Source files
------------

// File: rtl/chip_seq_gen.sv
// rtl/chip_seq_gen.sv - spreading-code sequencer: writable chip table played out at a divided chip rate
module chip_seq_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DIV_W  = 8
) (
  input  logic              clk_s,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_loop,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DIV_W-1:0]  chip_div,
  output logic [DATA_W-1:0] data,
  output logic              chip_stb,
  output logic              seq_start,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cfg_last;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_loop;
  logic              p1_valid;
  logic              p1_first;
  logic              start_go;
  logic              issue;
  logic              at_last;
  logic              finish;

  assign start_go = (state_q == S_IDLE) && start && !stop;
  assign issue    = (state_q == S_RUN) && (div_q == '0);
  assign at_last  = (addr_q == cfg_last);
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FLUSH waits out the chip period of the final read so the last strobe is never truncated
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop)                             state_d = S_IDLE;
        else if (issue && at_last && !cfg_loop) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (div_q == cfg_div) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Table: write-first ordering is not used, a same-address read sees the old word
  always_ff @(posedge clk_s) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    mem_q <= mem[addr_q];
  end

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      cfg_loop   <= 1'b0;
      cfg_last   <= '0;
      cfg_div    <= '0;
      addr_q     <= '0;
      div_q      <= '0;
      p1_valid   <= 1'b0;
      p1_first   <= 1'b0;
      data       <= '0;
      chip_stb   <= 1'b0;
      seq_start  <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (start_go) begin
        cfg_loop <= mode_loop;
        cfg_last <= last_addr;
        cfg_div  <= chip_div;
      end

      if (state_q != S_IDLE && state_d != S_IDLE)
        div_q <= (div_q == cfg_div) ? '0 : div_q + DIV_W'(1);
      else
        div_q <= '0;

      if (state_d == S_IDLE)
        addr_q <= '0;
      else if (issue)
        addr_q <= at_last ? '0 : addr_q + ADDR_W'(1);

      p1_valid <= issue && !stop;
      p1_first <= issue && (addr_q == '0);
      done     <= finish;

      if (stop && state_q != S_IDLE) begin
        data       <= '0;
        chip_stb   <= 1'b0;
        seq_start  <= 1'b0;
        data_valid <= 1'b0;
      end else begin
        chip_stb  <= p1_valid;
        seq_start <= p1_valid && p1_first;
        if (p1_valid) data <= mem_q;
        if (finish)        data_valid <= 1'b0;
        else if (p1_valid) data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip_seq_gen.sv
// tb/tb_chip_seq_gen.sv - randomized self-checking bench for chip_seq_gen against a cycle-formula model
module tb_chip_seq_gen;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int VW = 8;

  logic          clk_s = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic          mode_loop;
  logic [AW-1:0] last_addr;
  logic [VW-1:0] chip_div;
  logic [DW-1:0] data;
  logic          chip_stb;
  logic          seq_start;
  logic          data_valid;
  logic          busy;
  logic          done;

  int            checks = 0;
  int            failures = 0;
  int            cur_r = 0;
  logic [DW-1:0] tbl [8];
  logic [DW-1:0] exp_data;

  always #5 clk_s = ~clk_s;

  chip_seq_gen #(.DATA_W(DW), .ADDR_W(AW), .DIV_W(VW)) dut (
    .clk_s(clk_s), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .mode_loop(mode_loop), .last_addr(last_addr),
    .chip_div(chip_div), .data(data), .chip_stb(chip_stb), .seq_start(seq_start),
    .data_valid(data_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s r=%0d observed=%0h expected=%0h", tag, cur_r, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_chip_stb"}, 32'(chip_stb), 0);
    chk({tag, "_seq_start"}, 32'(seq_start), 0);
    chk({tag, "_data_valid"}, 32'(data_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic write_word(input int a, input int v);
    @(negedge clk_s);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(v);
    @(negedge clk_s);
    wr_en = 1'b0;
    tbl[a] = DW'(v);
  endtask

  // Start at relative cycle 0; reads issue at 1 + i*(d+1), each strobing two cycles later.
  task automatic run_play(input bit lp, input int last, input int d, input int stop_at,
                          input int wr_at, input int wr_a, input int wr_d);
    int n, r_last, e, end_c, span, c, i, a;
    logic stb, ss;
    logic [DW-1:0] word;
    n      = last + 1;
    r_last = 1 + (n - 1) * (d + 1);
    e      = r_last + ((d + 1 > 2) ? d + 1 : 2);
    end_c  = lp ? stop_at + 1 : e;
    span   = end_c + 3;
    @(negedge clk_s);
    mode_loop = lp; last_addr = AW'(last); chip_div = VW'(d); start = 1'b1; stop = 1'b0;
    for (int r = 1; r <= span; r++) begin
      @(negedge clk_s);
      cur_r = r;
      stb = 1'b0; ss = 1'b0; word = '0;
      c = r - 2;
      if (c >= 1 && (c - 1) % (d + 1) == 0) begin
        i = (c - 1) / (d + 1);
        if (lp || i < n) begin
          a    = i % n;
          word = (wr_at > 0 && c > wr_at && a == wr_a) ? DW'(wr_d) : tbl[a];
          stb  = 1'b1;
          ss   = (a == 0);
        end
      end
      if (lp && r >= end_c) begin
        stb = 1'b0; ss = 1'b0; exp_data = '0;
      end else if (stb) begin
        exp_data = word;
      end
      chk("chip_stb", 32'(chip_stb), 32'(stb));
      chk("seq_start", 32'(seq_start), 32'(ss));
      chk("data", 32'(data), 32'(exp_data));
      chk("busy", 32'(busy), 32'(r < end_c));
      chk("done", 32'(done), 32'(!lp && r == e));
      chk("data_valid", 32'(data_valid), 32'(r >= 3 && r < end_c));
      start     = (r < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop      = lp && (r == stop_at);
      mode_loop = 1'($urandom_range(0, 1));
      last_addr = AW'($urandom);
      chip_div  = VW'($urandom);
      wr_en     = (r == wr_at);
      wr_addr   = AW'(wr_a);
      wr_data   = DW'(wr_d);
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    if (wr_at > 0 && wr_at <= span) tbl[wr_a] = DW'(wr_d);
  endtask

  initial begin
    int lp, last, d, sa, wa, wat, wd;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
    mode_loop = 1'b0; last_addr = '0; chip_div = '0;
    exp_data = '0;
    repeat (2) @(negedge clk_s);
    cur_r = -1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++) write_word(k, (k + 1) * 8'h11);

    run_play(1'b0, 3, 0, 0, 0, 0, 0);
    run_play(1'b1, 1, 2, 20, 0, 0, 0);
    run_play(1'b1, 3, 0, 5, 0, 0, 0);
    run_play(1'b1, 3, 0, 14, 3, 2, 8'hA5);

    // Reset in the middle of a chip period
    @(negedge clk_s);
    mode_loop = 1'b1; last_addr = 3'd3; chip_div = 8'd2; start = 1'b1;
    repeat (6) begin
      @(negedge clk_s);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1 cur_r = -2;
    chk_all_zero("rst_mid");
    @(negedge clk_s);
    rst = 1'b0;
    exp_data = '0;

    // Simultaneous start and stop in IDLE
    @(negedge clk_s);
    start = 1'b1; stop = 1'b1; mode_loop = 1'b1; last_addr = 3'd2; chip_div = 8'd0;
    @(negedge clk_s);
    start = 1'b0; stop = 1'b0;
    cur_r = -3;
    chk("ss_busy", 32'(busy), 0);
    repeat (3) @(negedge clk_s);
    chk("ss_chip_stb", 32'(chip_stb), 0);
    chk("ss_data_valid", 32'(data_valid), 0);

    run_play(1'b0, 7, 1, 0, 0, 0, 0);
    run_play(1'b0, 0, 4, 0, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      lp   = int'($urandom_range(0, 1));
      last = int'($urandom_range(0, 7));
      d    = int'($urandom_range(0, 4));
      sa   = int'($urandom_range(2, 30));
      wat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      wa   = int'($urandom_range(0, 7));
      wd   = int'($urandom_range(0, 255));
      run_play(lp[0], last, d, sa, wat, wa, wd);
      repeat ($urandom_range(0, 3)) @(negedge clk_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
